multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle sequencing controller for the RISC-V core. It splits each instruction into FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states, so fetch and decode can run against memories with variable latency. It gates the single-cycle control outputs of `decode` (`wEn`, `mem_wEn`) so they fire only in the correct state. It also drives the instruction-register load and PC-update strobes, runs ready/request handshakes to instruction and data memory, counts retired instructions, and traps on illegal opcodes or memory timeouts.

## Interface
- `TIMEOUT`, default 255: max consecutive wait cycles per memory request. 0 disables the watchdog. Legal range 0–255.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `opcode`  in  7  `instruction[6:0]` from the instruction register.
- `dec_wEn`  in  1  register-file write enable from `decode`.
- `dec_mem_wEn`  in  1  memory write enable from `decode`.
- `imem_ready`  in  1  instruction memory has data for the current request.
- `dmem_ready`  in  1  data memory has completed the current access.
- `imem_req`  out  1  instruction fetch request.
- `ir_load`  out  1  latch the fetched instruction into the IR.
- `dmem_req`  out  1  data memory request.
- `mem_wEn`  out  1  gated data memory write enable.
- `rf_wEn`  out  1  gated register-file write enable.
- `pc_wEn`  out  1  commit the next PC, as selected by `decode`.
- `state`  out  3  current state encoding.
- `trap`  out  1  controller halted.
- `trap_cause`  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout.
- `instr_count`  out  32  retired-instruction counter.

## Operation
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=5. Codes 6–7 are unreachable and go to TRAP with cause 01.
- Legal opcodes: 0110011, 0010011, 0000011 (LOAD), 0100011 (STORE), 1100011, 1101111, 1100111, 0110111, 0010111. All other opcodes are illegal.
- **FETCH:**
  - `imem_req`=1.
  - If `imem_ready`=1: `ir_load`=1 in that cycle, next state DECODE.
  - Otherwise stay in FETCH.
- **DECODE:** one cycle. Illegal opcode → TRAP with cause 01; otherwise → EXECUTE.
- **EXECUTE:** one cycle. LOAD/STORE → MEMORY; all others → WRITEBACK.
- **MEMORY:**
  - `dmem_req`=1.
  - `mem_wEn` = `dec_mem_wEn` AND (opcode==STORE), held stable for every cycle in MEMORY.
  - `dmem_ready`=1 → WRITEBACK; otherwise stay.
- **WRITEBACK:** one cycle.
  - `rf_wEn`=`dec_wEn`, `pc_wEn`=1, `instr_count`+1 (wraps at 2^32).
  - Next state FETCH.
- **TRAP:**
  - `trap`=1 and `trap_cause` held.
  - All strobes are 0 and `instr_count` is frozen.
  - Only `reset` exits TRAP.
- All strobes (`imem_req`, `ir_load`, `dmem_req`, `mem_wEn`, `rf_wEn`, `pc_wEn`) are combinational functions of `state` and the inputs. All are 0 outside their own state.
- `imem_ready` is ignored outside FETCH; `dmem_ready` is ignored outside MEMORY.
- **Watchdog:**
  - An 8-bit `wait_cnt` clears on entry to FETCH or MEMORY and increments on each cycle in that state where ready=0.
  - If ready=0 and `wait_cnt`==`TIMEOUT`−1 → TRAP, cause 10 from FETCH or 11 from MEMORY.
  - Ready=1 in the same cycle takes priority over the timeout.

## Timing
- **Reset:**
  - While `reset`=1, all strobes are forced to 0 regardless of state.
  - At the edge: `state`=FETCH, `trap`=0, `trap_cause`=00, `instr_count`=0, `wait_cnt`=0.
  - First `imem_req` is in the first cycle after `reset` deasserts.
- Reset asserted mid-instruction (any state, including MEMORY with a write pending) aborts the instruction. No retire and no count increment.
- **Zero-wait cycle counts:**
  - Non-memory instruction: 4 cycles (F, D, E, W).
  - LOAD/STORE: 5 cycles.
  - Each wait cycle in FETCH or MEMORY adds 1.
- Handshake: req rises on state entry and stays high until the edge where ready=1 is sampled. The state advances at that edge. Ready may already be high on the first req cycle.
- `ir_load` and the IR capture share the FETCH-exit edge. `opcode` is valid from DECODE onward.
- `dec_*` inputs must be stable from DECODE through WRITEBACK. They depend only on the IR.

## Test plan
- **R-type, zero-wait:** reset, `imem_ready`=1, opcode=0110011, `dec_wEn`=1. Required: `state` sequence 0,1,2,4,0; `rf_wEn` and `pc_wEn` high only in the state-4 cycle; `instr_count`=1 after 4 cycles and 3 after 12.
- **LOAD with data wait:** opcode=0000011, `dmem_ready` low for 2 MEMORY cycles then high. Required: `state` sequence 0,1,2,3,3,3,4 (7 cycles); `mem_wEn`=0 throughout; `rf_wEn`=1 in WRITEBACK.
- **STORE:** opcode=0100011, `dec_mem_wEn`=1, `dec_wEn`=0, `dmem_ready` high on the 2nd MEMORY cycle. Required: `mem_wEn` and `dmem_req` high for exactly 2 cycles; `rf_wEn`=0; count +1.
- **Illegal opcode:** opcode=1111111. Required: DECODE→TRAP, `trap`=1, `trap_cause`=01, all strobes 0 for 20 cycles, count unchanged; after `reset`, back in FETCH with count 0.
- **Watchdog** (`TIMEOUT`=4):
  - `imem_ready`=0 → TRAP after 4 FETCH cycles, `trap_cause`=10.
  - Repeat with `imem_ready`=1 in the 4th cycle → DECODE, no trap.
  - Same checks on MEMORY give cause 11.
- **Reset mid-MEMORY:** STORE stalled in MEMORY; assert `reset` for one cycle. Required: `mem_wEn`=0 during the reset cycle, `state`=FETCH after it, `instr_count`=0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// ============================================================================
// multicycle_ctrl_if : control/handshake bundle between multicycle_ctrl and core
// Revision: 1.0
// ============================================================================
`default_nettype none

interface multicycle_ctrl_if;
  logic [6:0]  opcode;
  logic        dec_wEn;
  logic        dec_mem_wEn;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req;
  logic        ir_load;
  logic        dmem_req;
  logic        mem_wEn;
  logic        rf_wEn;
  logic        pc_wEn;
  logic [2:0]  state;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] instr_count;

  modport master (
    input  opcode, dec_wEn, dec_mem_wEn, imem_ready, dmem_ready,
    output imem_req, ir_load, dmem_req, mem_wEn, rf_wEn, pc_wEn,
    output state, trap, trap_cause, instr_count
  );

  modport slave (
    output opcode, dec_wEn, dec_mem_wEn, imem_ready, dmem_ready,
    input  imem_req, ir_load, dmem_req, mem_wEn, rf_wEn, pc_wEn,
    input  state, trap, trap_cause, instr_count
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl : FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with
//                   memory handshakes, retire counter and trap/watchdog logic
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  wire logic         clock,
  input  wire logic         reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam bit         WATCHDOG_ON = (TIMEOUT != 0);
  localparam logic [7:0] WAIT_LIMIT  = WATCHDOG_ON ? 8'(TIMEOUT - 1) : 8'd0;

  state_t      cur_state;
  logic        trap_flag;
  logic [1:0]  cause;
  logic [31:0] retired;
  logic [7:0]  wait_cnt;

  logic        opcode_legal;
  logic        opcode_mem;
  logic        wait_expired;

  always_comb begin
    opcode_legal = 1'b0;
    case (bus.opcode)
      OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: opcode_legal = 1'b1;
      default:                           opcode_legal = 1'b0;
    endcase
  end

  assign opcode_mem   = (bus.opcode == OP_LOAD) || (bus.opcode == OP_STORE);
  assign wait_expired = WATCHDOG_ON && (wait_cnt == WAIT_LIMIT);

  // Strobes are decoded from the current state; reset overrides every state.
  always_comb begin
    bus.imem_req = 1'b0;
    bus.ir_load  = 1'b0;
    bus.dmem_req = 1'b0;
    bus.mem_wEn  = 1'b0;
    bus.rf_wEn   = 1'b0;
    bus.pc_wEn   = 1'b0;
    if (!reset) begin
      case (cur_state)
        S_FETCH: begin
          bus.imem_req = 1'b1;
          bus.ir_load  = bus.imem_ready;
        end
        S_MEMORY: begin
          bus.dmem_req = 1'b1;
          bus.mem_wEn  = bus.dec_mem_wEn && (bus.opcode == OP_STORE);
        end
        S_WRITEBACK: begin
          bus.rf_wEn = bus.dec_wEn;
          bus.pc_wEn = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // wait_cnt is zeroed on every state change, so it starts at 0 on entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_state <= S_FETCH;
      trap_flag <= 1'b0;
      cause     <= CAUSE_NONE;
      retired   <= 32'd0;
      wait_cnt  <= 8'd0;
    end else begin
      case (cur_state)
        S_FETCH: begin
          if (bus.imem_ready) begin
            cur_state <= S_DECODE;
            wait_cnt  <= 8'd0;
          end else if (wait_expired) begin
            cur_state <= S_TRAP;
            trap_flag <= 1'b1;
            cause     <= CAUSE_IMEM_TO;
            wait_cnt  <= 8'd0;
          end else begin
            wait_cnt  <= wait_cnt + 8'd1;
          end
        end
        S_DECODE: begin
          wait_cnt <= 8'd0;
          if (opcode_legal) begin
            cur_state <= S_EXECUTE;
          end else begin
            cur_state <= S_TRAP;
            trap_flag <= 1'b1;
            cause     <= CAUSE_ILLEGAL;
          end
        end
        S_EXECUTE: begin
          wait_cnt  <= 8'd0;
          cur_state <= opcode_mem ? S_MEMORY : S_WRITEBACK;
        end
        S_MEMORY: begin
          if (bus.dmem_ready) begin
            cur_state <= S_WRITEBACK;
            wait_cnt  <= 8'd0;
          end else if (wait_expired) begin
            cur_state <= S_TRAP;
            trap_flag <= 1'b1;
            cause     <= CAUSE_DMEM_TO;
            wait_cnt  <= 8'd0;
          end else begin
            wait_cnt  <= wait_cnt + 8'd1;
          end
        end
        S_WRITEBACK: begin
          cur_state <= S_FETCH;
          retired   <= retired + 32'd1;
          wait_cnt  <= 8'd0;
        end
        S_TRAP: begin
          cur_state <= S_TRAP;
        end
        default: begin
          cur_state <= S_TRAP;
          trap_flag <= 1'b1;
          cause     <= CAUSE_ILLEGAL;
          wait_cnt  <= 8'd0;
        end
      endcase
    end
  end

  assign bus.state       = cur_state;
  assign bus.trap        = trap_flag;
  assign bus.trap_cause  = cause;
  assign bus.instr_count = retired;

endmodule

`default_nettype wire
